// File: rtl/spi_slave_stream.sv
// rtl/spi_slave_stream.sv - oversampled SPI mode-0 slave bridging WIDTH-bit words to a valid/ready stream
// Optional overrun counter port enabled by defining SPI_OVERRUN_COUNT_EN.
module spi_slave_stream #(
  parameter int WIDTH       = 8,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sck,
  input  logic             sdi,
  input  logic             ss_n,
  output logic             sdo,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ack,
  output logic             overrun,
  output logic             busy
`ifdef SPI_OVERRUN_COUNT_EN
  ,
  output logic [7:0]       overrun_count
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, state_d;

  logic [SYNC_STAGES-1:0] sck_sr, sdi_sr, ss_sr;
  logic                   sck_prev, ss_prev;
  logic                   sck_s, sdi_s, ss_s;
  logic                   sck_rise, sck_fall, ss_fall;

  logic [CW-1:0]          bit_cnt;
  logic [WIDTH-1:0]       rx_sh, tx_sh;
  logic [WIDTH-1:0]       rx_next, tx_next;

  logic                   load_tx, clr_cnt, rise_en, fall_en, word_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sr   <= '0;
      sdi_sr   <= '0;
      ss_sr    <= '1;
      sck_prev <= 1'b0;
      ss_prev  <= 1'b1;
    end else begin
      sck_sr   <= {sck_sr[SYNC_STAGES-2:0], sck};
      sdi_sr   <= {sdi_sr[SYNC_STAGES-2:0], sdi};
      ss_sr    <= {ss_sr[SYNC_STAGES-2:0], ss_n};
      sck_prev <= sck_sr[SYNC_STAGES-1];
      ss_prev  <= ss_sr[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sr[SYNC_STAGES-1];
  assign sdi_s    = sdi_sr[SYNC_STAGES-1];
  assign ss_s     = ss_sr[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;
  assign ss_fall  = ~ss_s & ss_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // The sck fall that follows a word's last rise is skipped (counter is 0 then),
  // otherwise it would shift away the first bit of the freshly reloaded word.
  always_comb begin
    state_d = state;
    clr_cnt = 1'b0;
    rise_en = 1'b0;
    fall_en = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_d = ACTIVE;
          clr_cnt = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_s) begin
          state_d = IDLE;
          clr_cnt = 1'b1;
        end else begin
          rise_en = sck_rise;
          fall_en = sck_fall && (bit_cnt != '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign word_done = rise_en && (bit_cnt == CW'(WIDTH - 1));
  assign load_tx   = (state == IDLE && ss_fall) || word_done;

  always_comb begin
    if (MSB_FIRST != 0) begin
      rx_next = {rx_sh[WIDTH-2:0], sdi_s};
      tx_next = {tx_sh[WIDTH-2:0], 1'b0};
    end else begin
      rx_next = {sdi_s, rx_sh[WIDTH-1:1]};
      tx_next = {1'b0, tx_sh[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt  <= '0;
      rx_sh    <= '0;
      tx_sh    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_ack   <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      tx_ack  <= 1'b0;
      overrun <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (clr_cnt) bit_cnt <= '0;
      if (rise_en) begin
        rx_sh   <= rx_next;
        bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
      end
      if (word_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
      if (load_tx) begin
        if (tx_valid) begin
          tx_sh  <= tx_data;
          tx_ack <= 1'b1;
        end else begin
          tx_sh <= '0;
        end
      end else if (fall_en) begin
        tx_sh <= tx_next;
      end
    end
  end

`ifdef SPI_OVERRUN_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            overrun_count <= 8'd0;
    else if (overrun && overrun_count != 8'hFF) overrun_count <= overrun_count + 8'd1;
  end
`endif

  assign busy = (state == ACTIVE);
  assign sdo  = busy && ((MSB_FIRST != 0) ? tx_sh[WIDTH-1] : tx_sh[0]);

endmodule

// File: tb/tb_spi_slave_stream.sv
// tb/tb_spi_slave_stream.sv - table-driven and randomized bench for spi_slave_stream
module tb_spi_slave_stream;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sck = 1'b0, sdi = 1'b0;
  logic        ss_n = 1'b1, ss12_n = 1'b1;
  logic        sdo, sdo12;
  logic [7:0]  rx_data, tx_data = 8'h00;
  logic [11:0] rx_data12;
  logic        rx_valid, rx_ready = 1'b1, tx_valid = 1'b0, tx_ack, overrun, busy;
  logic        rx_valid12, tx_ack12, overrun12, busy12;
`ifdef SPI_OVERRUN_COUNT_EN
  logic [7:0]  overrun_count, overrun_count12;
`endif

  always #5 clk = ~clk;

  spi_slave_stream #(.WIDTH(8), .MSB_FIRST(1), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .ss_n(ss_n), .sdo(sdo),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ack(tx_ack),
    .overrun(overrun), .busy(busy)
`ifdef SPI_OVERRUN_COUNT_EN
    , .overrun_count(overrun_count)
`endif
  );

  spi_slave_stream #(.WIDTH(12), .MSB_FIRST(0), .SYNC_STAGES(2)) dut12 (
    .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .ss_n(ss12_n), .sdo(sdo12),
    .rx_data(rx_data12), .rx_valid(rx_valid12), .rx_ready(1'b1),
    .tx_data(12'h000), .tx_valid(1'b0), .tx_ack(tx_ack12),
    .overrun(overrun12), .busy(busy12)
`ifdef SPI_OVERRUN_COUNT_EN
    , .overrun_count(overrun_count12)
`endif
  );

  int n_vec = 0, n_err = 0;
  int ack_cnt = 0, ovr_cnt = 0;
  logic [31:0] got[$];
  logic [31:0] got12[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid && rx_ready) got.push_back(32'(rx_data));
      if (rx_valid12) got12.push_back(32'(rx_data12));
      if (tx_ack) ack_cnt++;
      if (overrun) ovr_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pop_chk(input string name, input bit which, input logic [31:0] exp);
    if ((which ? got12.size() : got.size()) == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: no word received, expected %h", name, exp);
    end else begin
      chk(name, which ? got12.pop_front() : got.pop_front(), exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input bit which, input logic [31:0] w, input int n, input bit msb,
                           input logic [7:0] ntx, input logic ntxv, output logic [31:0] miso);
    int idx;
    miso = '0;
    for (int i = 0; i < n; i++) begin
      idx = msb ? n - 1 - i : i;
      sdi = w[idx];
      if (i == n - 1) begin
        tx_data  = ntx;
        tx_valid = ntxv;
      end
      clks(8);
      miso[idx] = which ? sdo12 : sdo;
      sck = 1'b1;
      clks(8);
      sck = 1'b0;
    end
  endtask

  task automatic frame8(input logic [7:0] mosi, input logic [7:0] txd, input logic txv,
                        output logic [31:0] miso);
    tx_data  = txd;
    tx_valid = txv;
    clks(1);
    ss_n = 1'b0;
    clks(8);
    send_word(1'b0, 32'(mosi), 8, 1'b1, 8'h00, 1'b0, miso);
    clks(4);
    ss_n = 1'b1;
    clks(8);
  endtask

  typedef struct {
    logic [7:0] mosi;
    logic [7:0] txd;
    logic       txv;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
    int         exp_ack;
  } vec_t;

  vec_t tbl[4];

  initial begin
    logic [31:0] miso;
    logic [7:0]  w_mosi[4], w_txd[4];
    logic        w_txv[4];
    int          nw, exp_ack;

    tbl[0] = '{8'hA5, 8'hC3, 1'b1, 8'hA5, 8'hC3, 1};
    tbl[1] = '{8'h3C, 8'h99, 1'b0, 8'h3C, 8'h00, 0};
    tbl[2] = '{8'h00, 8'hFF, 1'b1, 8'h00, 8'hFF, 1};
    tbl[3] = '{8'hFF, 8'h5A, 1'b1, 8'hFF, 8'h5A, 1};

    clks(3);
    chk("reset_outputs", {24'd0, rx_data, rx_valid, tx_ack, overrun, busy, sdo}, 32'd0);
    reset = 1'b0;
    clks(4);
    chk("idle_busy_sdo", {30'd0, busy, sdo}, 32'd0);

    for (int v = 0; v < 4; v++) begin
      ack_cnt = 0;
      got.delete();
      frame8(tbl[v].mosi, tbl[v].txd, tbl[v].txv, miso);
      pop_chk($sformatf("tbl%0d_rx", v), 1'b0, 32'(tbl[v].exp_rx));
      chk($sformatf("tbl%0d_miso", v), miso, 32'(tbl[v].exp_miso));
      chk($sformatf("tbl%0d_ack", v), 32'(ack_cnt), 32'(tbl[v].exp_ack));
    end

    // Randomized multi-word frames against a queue model of the word stream.
    ovr_cnt = 0;
    for (int f = 0; f < 6; f++) begin
      nw = $urandom_range(2, 4);
      exp_ack = 0;
      ack_cnt = 0;
      got.delete();
      for (int k = 0; k < nw; k++) begin
        w_mosi[k] = 8'($urandom);
        w_txd[k]  = 8'($urandom);
        w_txv[k]  = 1'($urandom);
        if (w_txv[k]) exp_ack++;
      end
      if (f == 0) begin
        w_mosi[0] = 8'hA5;
        w_mosi[1] = 8'h3C;
      end
      tx_data  = w_txd[0];
      tx_valid = w_txv[0];
      clks(1);
      ss_n = 1'b0;
      clks(8);
      chk("rnd_busy", 32'(busy), 32'd1);
      for (int k = 0; k < nw; k++) begin
        send_word(1'b0, 32'(w_mosi[k]), 8, 1'b1,
                  (k + 1 < nw) ? w_txd[k+1] : 8'h00, (k + 1 < nw) ? w_txv[k+1] : 1'b0, miso);
        chk($sformatf("rnd%0d_w%0d_miso", f, k), miso, w_txv[k] ? 32'(w_txd[k]) : 32'd0);
      end
      clks(4);
      ss_n = 1'b1;
      clks(8);
      chk($sformatf("rnd%0d_count", f), 32'(got.size()), 32'(nw));
      for (int k = 0; k < nw; k++) pop_chk($sformatf("rnd%0d_w%0d_rx", f, k), 1'b0, 32'(w_mosi[k]));
      chk($sformatf("rnd%0d_ack", f), 32'(ack_cnt), 32'(exp_ack));
    end
    chk("no_overrun", 32'(ovr_cnt), 32'd0);

    // Overrun: consumer stalled across two words.
    rx_ready = 1'b0;
    got.delete();
    tx_valid = 1'b0;
    clks(1);
    ss_n = 1'b0;
    clks(8);
    send_word(1'b0, 32'h11, 8, 1'b1, 8'h00, 1'b0, miso);
    send_word(1'b0, 32'h22, 8, 1'b1, 8'h00, 1'b0, miso);
    clks(4);
    ss_n = 1'b1;
    clks(8);
    chk("ovr_rx_data", 32'(rx_data), 32'h11);
    chk("ovr_rx_valid", 32'(rx_valid), 32'd1);
    chk("ovr_pulses", 32'(ovr_cnt), 32'd1);
`ifdef SPI_OVERRUN_COUNT_EN
    chk("ovr_count", 32'(overrun_count), 32'd1);
`endif
    rx_ready = 1'b1;
    clks(3);
    pop_chk("ovr_drain", 1'b0, 32'h11);
    chk("ovr_drained_valid", 32'(rx_valid), 32'd0);

    // Partial word discarded on early ss_n release.
    got.delete();
    ss_n = 1'b0;
    clks(8);
    send_word(1'b0, 32'hFF, 5, 1'b1, 8'h00, 1'b0, miso);
    clks(4);
    ss_n = 1'b1;
    clks(8);
    chk("partial_none", 32'(got.size()), 32'd0);
    frame8(8'h81, 8'h00, 1'b0, miso);
    chk("partial_count", 32'(got.size()), 32'd1);
    pop_chk("partial_next", 1'b0, 32'h81);

    // 12-bit LSB-first instance.
    got12.delete();
    ss12_n = 1'b0;
    clks(8);
    send_word(1'b1, 32'h5A3, 12, 1'b0, 8'h00, 1'b0, miso);
    clks(4);
    ss12_n = 1'b1;
    clks(8);
    pop_chk("w12_rx", 1'b1, 32'h5A3);
    chk("w12_miso", miso, 32'd0);

    // Reset mid-frame.
    got.delete();
    ss_n = 1'b0;
    clks(8);
    send_word(1'b0, 32'h0F, 4, 1'b1, 8'h00, 1'b0, miso);
    reset = 1'b1;
    clks(1);
    chk("rst_mid_outputs", {24'd0, rx_data, rx_valid, tx_ack, overrun, busy, sdo}, 32'd0);
    ss_n = 1'b1;
    clks(3);
    reset = 1'b0;
    clks(8);
    chk("rst_idle", 32'(busy), 32'd0);
    frame8(8'h7E, 8'h00, 1'b0, miso);
    pop_chk("rst_resume", 1'b0, 32'h7E);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
